// File: rtl/y86_dmem_stage_pkg.sv
// Shared constants for the Y86-64 memory stage: icodes, status codes, widths.
package y86_dmem_stage_pkg;
    localparam int D_WORD = 64;
    localparam int NIBBLE = 4;
    localparam int BYTE   = 8;

    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;
    localparam logic [NIBBLE-1:0] IIADDQ  = 4'hC;

    localparam logic [NIBBLE-1:0] SAOK = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT = 4'h2;
    localparam logic [NIBBLE-1:0] SADR = 4'h3;
    localparam logic [NIBBLE-1:0] SINS = 4'h4;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_state_e;

    function automatic logic is_write(input logic [NIBBLE-1:0] ic);
        return ic == IRMMOVQ || ic == IPUSHQ || ic == ICALL;
    endfunction

    function automatic logic is_read(input logic [NIBBLE-1:0] ic);
        return ic == IMRMOVQ || ic == IPOPQ || ic == IRET;
    endfunction
endpackage

// File: rtl/y86_dmem_stage_byte_ram.sv
// Little-endian byte RAM: 8-byte write port, 8-byte read port that is
// combinational when READ_LAT==0 and registered otherwise.
module y86_byte_ram
    import y86_dmem_stage_pkg::*;
#(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    READ_LAT    = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] waddr_i,
    input  logic [D_WORD-1:0]              wdata_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] raddr_i,
    output logic [D_WORD-1:0]              rdata_o
);
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [BYTE-1:0]   mem [DEPTH_BYTES];
    logic [D_WORD-1:0] rd_word;

    initial begin
        for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = '0;
    end

    // Callers only pass addresses with the whole word in range, so no wrap.
    always @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 8; k++) mem[waddr_i + AW'(k)] <= wdata_i[8*k +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) rd_word[8*k +: 8] = mem[raddr_i + AW'(k)];
    end

    generate
        if (READ_LAT == 0) begin : g_comb
            assign rdata_o = rd_word;
        end else begin : g_reg
            logic [D_WORD-1:0] rdata_q;
            always_ff @(posedge clk_i) rdata_q <= rd_word;
            assign rdata_o = rdata_q;
        end
    endgenerate
endmodule

// File: rtl/y86_dmem_stage.sv
// Y86-64 memory stage: decode, bounds check, sticky write suppression and
// a multi-cycle read FSM that stalls the pipeline for READ_LAT cycles.
module y86_dmem_stage
    import y86_dmem_stage_pkg::*;
#(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    READ_LAT    = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              M_valid_i,
    input  logic [NIBBLE-1:0] M_stat_i,
    input  logic [NIBBLE-1:0] M_icode_i,
    input  logic [D_WORD-1:0] M_valE_i,
    input  logic [D_WORD-1:0] M_valA_i,
    output logic              m_stall_o,
    output logic              m_valid_o,
    output logic [NIBBLE-1:0] m_stat_o,
    output logic [D_WORD-1:0] m_valM_o
);
    localparam int AW       = $clog2(DEPTH_BYTES);
    localparam int CNT_INIT = (READ_LAT > 0) ? READ_LAT - 1 : 0;

    rd_state_e         state_q;
    logic [1:0]        cnt_q;
    logic [AW-1:0]     addr_q;
    logic              halted_q;

    logic              wr_op, rd_op, addr_err, rd_ok, we, halt_set;
    logic [D_WORD-1:0] addr, ram_rdata;
    logic [AW-1:0]     raddr;

    assign wr_op    = is_write(M_icode_i);
    assign rd_op    = is_read(M_icode_i);
    assign addr     = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
    assign addr_err = (wr_op || rd_op) && (addr > D_WORD'(DEPTH_BYTES - 8));
    assign rd_ok    = M_valid_i && rd_op && !addr_err;
    assign we       = M_valid_i && wr_op && !addr_err && (M_stat_i == SAOK)
                      && !halted_q && !rst_i;

    // Stall is combinational so the hazard unit freezes M in the issue cycle.
    assign m_stall_o = !rst_i && (READ_LAT > 0)
                       && ((state_q == RD_IDLE && rd_ok) || state_q == RD_WAIT);
    assign m_valid_o = !rst_i && M_valid_i && !m_stall_o;
    assign m_stat_o  = rst_i ? SAOK : (M_valid_i && addr_err) ? SADR : M_stat_i;
    assign m_valM_o  = (m_valid_o && rd_op && !addr_err) ? ram_rdata : '0;
    assign halt_set  = m_valid_o && (m_stat_o != SAOK);

    // Once a read is issued the RAM sees only the latched address.
    assign raddr = (READ_LAT == 0 || state_q == RD_IDLE) ? addr[AW-1:0] : addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RD_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            if (halt_set) halted_q <= 1'b1;
            case (state_q)
                RD_IDLE: begin
                    if (READ_LAT > 0 && rd_ok) begin
                        addr_q  <= addr[AW-1:0];
                        cnt_q   <= 2'(CNT_INIT);
                        state_q <= (READ_LAT == 1) ? RD_DONE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_q <= RD_DONE;
                end
                RD_DONE: state_q <= RD_IDLE;
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    y86_byte_ram #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .READ_LAT   (READ_LAT),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (we),
        .waddr_i(addr[AW-1:0]),
        .wdata_i(M_valA_i),
        .raddr_i(raddr),
        .rdata_o(ram_rdata)
    );
endmodule

// File: tb/tb_y86_dmem_stage.sv
// Directed bench for y86_dmem_stage: three instances (READ_LAT 2, 3, 0) share one M bus.
module tb_y86_dmem_stage;
    import y86_dmem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [3:0]  stat, icode;
    logic [63:0] valE, valA;

    logic        st2, v2, st3, v3, st0, v0;
    logic [3:0]  s2, s3, s0;
    logic [63:0] m2, m3, m0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    y86_dmem_stage #(.DEPTH_BYTES(1024), .READ_LAT(2), .INIT_FILE("")) u_l2 (
        .clk_i(clk), .rst_i(rst), .M_valid_i(vld), .M_stat_i(stat), .M_icode_i(icode),
        .M_valE_i(valE), .M_valA_i(valA),
        .m_stall_o(st2), .m_valid_o(v2), .m_stat_o(s2), .m_valM_o(m2));

    y86_dmem_stage #(.DEPTH_BYTES(1024), .READ_LAT(3), .INIT_FILE("")) u_l3 (
        .clk_i(clk), .rst_i(rst), .M_valid_i(vld), .M_stat_i(stat), .M_icode_i(icode),
        .M_valE_i(valE), .M_valA_i(valA),
        .m_stall_o(st3), .m_valid_o(v3), .m_stat_o(s3), .m_valM_o(m3));

    y86_dmem_stage #(.DEPTH_BYTES(1024), .READ_LAT(0), .INIT_FILE("")) u_l0 (
        .clk_i(clk), .rst_i(rst), .M_valid_i(vld), .M_stat_i(stat), .M_icode_i(icode),
        .M_valE_i(valE), .M_valA_i(valA),
        .m_stall_o(st0), .m_valid_o(v0), .m_stat_o(s0), .m_valM_o(m0));

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [3:0] s, input logic [3:0] ic,
                         input logic [63:0] e, input logic [63:0] a);
        @(negedge clk);
        vld = v; stat = s; icode = ic; valE = e; valA = a;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; stat = SAOK; icode = INOP; valE = '0; valA = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; vld = 1'b1; stat = SAOK; icode = IMRMOVQ; valE = 64'h10; valA = '0;
        #1;
        nvec++; if (st2 !== 1'b0) begin nerr++; $display("FAIL rst_stall got %0b exp 0", st2); end
        nvec++; if (v2 !== 1'b0) begin nerr++; $display("FAIL rst_valid got %0b exp 0", v2); end
        nvec++; if (s2 !== SAOK) begin nerr++; $display("FAIL rst_stat got %0h exp %0h", s2, SAOK); end
        nvec++; if (m2 !== 64'h0) begin nerr++; $display("FAIL rst_valM got %0h exp 0", m2); end
        @(negedge clk);
        rst = 1'b0; vld = 1'b0; stat = SHLT; icode = INOP;
        #1;
        nvec++; if (st2 !== 1'b0 || v2 !== 1'b0) begin nerr++; $display("FAIL bubble_idle got stall=%0b valid=%0b exp 0/0", st2, v2); end
        nvec++; if (s2 !== SHLT) begin nerr++; $display("FAIL bubble_stat got %0h exp %0h", s2, SHLT); end
        nvec++; if (m2 !== 64'h0) begin nerr++; $display("FAIL bubble_valM got %0h exp 0", m2); end
    endtask

    task automatic test_write_read();
        int n;
        pulse_reset();
        drive(1'b1, SAOK, IRMMOVQ, 64'h10, 64'h1122334455667788);
        nvec++; if (st2 !== 1'b0 || v2 !== 1'b1 || s2 !== SAOK) begin nerr++; $display("FAIL wr_out got stall=%0b valid=%0b stat=%0h exp 0/1/1", st2, v2, s2); end
        nvec++; if (m2 !== 64'h0) begin nerr++; $display("FAIL wr_valM got %0h exp 0", m2); end
        drive(1'b1, SAOK, IMRMOVQ, 64'h10, 64'h0);
        nvec++; if (st2 !== 1'b1 || v2 !== 1'b0) begin nerr++; $display("FAIL rd_issue got stall=%0b valid=%0b exp 1/0", st2, v2); end
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (n != 2) begin nerr++; $display("FAIL rd_stall_cycles got %0d exp 2", n); end
        nvec++; if (v2 !== 1'b1 || s2 !== SAOK) begin nerr++; $display("FAIL rd_done got valid=%0b stat=%0h exp 1/1", v2, s2); end
        nvec++; if (m2 !== 64'h1122334455667788) begin nerr++; $display("FAIL rd_data got %0h exp 1122334455667788", m2); end
        // Unaligned read at 0x0C: byte 0x10 lands in bits 39:32.
        drive(1'b1, SAOK, IMRMOVQ, 64'h0C, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2[63:32] !== 32'h55667788) begin nerr++; $display("FAIL rd_le_bytes got %0h exp 55667788", m2[63:32]); end
    endtask

    task automatic test_upper_bound();
        int n;
        pulse_reset();
        drive(1'b1, SAOK, IRMMOVQ, 64'd1016, 64'hCAFEF00D12345678);
        nvec++; if (s2 !== SAOK || v2 !== 1'b1) begin nerr++; $display("FAIL ub_wr got stat=%0h valid=%0b exp 1/1", s2, v2); end
        drive(1'b1, SAOK, IMRMOVQ, 64'd1016, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (n != 2) begin nerr++; $display("FAIL ub_stall got %0d exp 2", n); end
        nvec++; if (s2 !== SAOK || m2 !== 64'hCAFEF00D12345678) begin nerr++; $display("FAIL ub_rd1016 got stat=%0h data=%0h exp 1/cafef00d12345678", s2, m2); end
        drive(1'b1, SAOK, IMRMOVQ, 64'd1017, 64'h0);
        nvec++; if (st2 !== 1'b0 || v2 !== 1'b1) begin nerr++; $display("FAIL ub_1017_hs got stall=%0b valid=%0b exp 0/1", st2, v2); end
        nvec++; if (s2 !== SADR || m2 !== 64'h0) begin nerr++; $display("FAIL ub_1017 got stat=%0h data=%0h exp 3/0", s2, m2); end
        drive(1'b1, SAOK, IPOPQ, 64'h0, 64'd1020);
        nvec++; if (s2 !== SADR || st2 !== 1'b0) begin nerr++; $display("FAIL ub_popq got stat=%0h stall=%0b exp 3/0", s2, st2); end
        drive(1'b1, SAOK, IPOPQ, 64'h8, 64'd1016);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'hCAFEF00D12345678) begin nerr++; $display("FAIL halted_popq_rd got %0h exp cafef00d12345678", m2); end
    endtask

    task automatic test_sticky_halt();
        int n;
        pulse_reset();
        drive(1'b1, SAOK, IRMMOVQ, 64'h20, 64'h0);
        drive(1'b1, SAOK, IRMMOVQ, 64'd2000, 64'h55);
        nvec++; if (s2 !== SADR || v2 !== 1'b1) begin nerr++; $display("FAIL halt_sadr got stat=%0h valid=%0b exp 3/1", s2, v2); end
        drive(1'b1, SAOK, IRMMOVQ, 64'h20, 64'hAB);
        nvec++; if (s2 !== SAOK) begin nerr++; $display("FAIL halt_wr_stat got %0h exp 1", s2); end
        drive(1'b1, SAOK, IMRMOVQ, 64'h20, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'h0) begin nerr++; $display("FAIL halt_suppress got %0h exp 0", m2); end
        pulse_reset();
        drive(1'b1, SAOK, IMRMOVQ, 64'h20, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'h0) begin nerr++; $display("FAIL halt_after_rst got %0h exp 0", m2); end
        drive(1'b1, SAOK, IRMMOVQ, 64'h20, 64'hAB);
        drive(1'b1, SAOK, IMRMOVQ, 64'h20, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'hAB) begin nerr++; $display("FAIL halt_cleared got %0h exp ab", m2); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        pulse_reset();
        drive(1'b1, SAOK, IRMMOVQ, 64'h30, 64'h0102030405060708);
        drive(1'b1, SAOK, IMRMOVQ, 64'h30, 64'h0);
        nvec++; if (st3 !== 1'b1) begin nerr++; $display("FAIL l3_issue got stall=%0b exp 1", st3); end
        @(negedge clk); #1;
        nvec++; if (st3 !== 1'b1 || v3 !== 1'b0) begin nerr++; $display("FAIL l3_wait got stall=%0b valid=%0b exp 1/0", st3, v3); end
        rst = 1'b1; vld = 1'b0;
        #1;
        nvec++; if (st3 !== 1'b0 || v3 !== 1'b0 || s3 !== SAOK) begin nerr++; $display("FAIL l3_in_rst got stall=%0b valid=%0b stat=%0h exp 0/0/1", st3, v3, s3); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++; if (st3 !== 1'b0 || v3 !== 1'b0 || m3 !== 64'h0) begin nerr++; $display("FAIL l3_after_rst got stall=%0b valid=%0b data=%0h exp 0/0/0", st3, v3, m3); end
        drive(1'b1, SAOK, IMRMOVQ, 64'h30, 64'h0);
        n = 0;
        while (st3 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (n != 3) begin nerr++; $display("FAIL l3_stall_cycles got %0d exp 3", n); end
        nvec++; if (v3 !== 1'b1 || m3 !== 64'h0102030405060708) begin nerr++; $display("FAIL l3_data got valid=%0b data=%0h exp 1/0102030405060708", v3, m3); end
    endtask

    task automatic test_lat0();
        pulse_reset();
        drive(1'b1, SAOK, IPUSHQ, 64'h40, 64'hDEAD);
        nvec++; if (st0 !== 1'b0 || v0 !== 1'b1) begin nerr++; $display("FAIL l0_push got stall=%0b valid=%0b exp 0/1", st0, v0); end
        drive(1'b1, SAOK, IPOPQ, 64'h48, 64'h40);
        nvec++; if (st0 !== 1'b0 || v0 !== 1'b1) begin nerr++; $display("FAIL l0_pop_hs got stall=%0b valid=%0b exp 0/1", st0, v0); end
        nvec++; if (m0 !== 64'hDEAD) begin nerr++; $display("FAIL l0_pop_data got %0h exp dead", m0); end
        drive(1'b1, SAOK, IRMMOVQ, 64'h40, 64'h0123456789ABCDEF);
        drive(1'b1, SAOK, IRET, 64'h0, 64'h40);
        nvec++; if (st0 !== 1'b0 || m0 !== 64'h0123456789ABCDEF) begin nerr++; $display("FAIL l0_raw got stall=%0b data=%0h exp 0/0123456789abcdef", st0, m0); end
    endtask

    task automatic test_bubble_other();
        int n;
        pulse_reset();
        drive(1'b1, SAOK, IRMMOVQ, 64'h50, 64'h1234);
        drive(1'b0, SAOK, IRMMOVQ, 64'h50, 64'hFFFF);
        nvec++; if (v2 !== 1'b0 || st2 !== 1'b0) begin nerr++; $display("FAIL bub_hs got valid=%0b stall=%0b exp 0/0", v2, st2); end
        drive(1'b1, SAOK, IMRMOVQ, 64'h50, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'h1234) begin nerr++; $display("FAIL bub_no_write got %0h exp 1234", m2); end
        drive(1'b1, SAOK, ICALL, 64'h60, 64'h777);
        drive(1'b1, SAOK, IRET, 64'h0, 64'h60);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'h777) begin nerr++; $display("FAIL call_ret got %0h exp 777", m2); end
        drive(1'b1, SAOK, IOPQ, 64'h50, 64'h60);
        nvec++; if (v2 !== 1'b1 || st2 !== 1'b0 || m2 !== 64'h0) begin nerr++; $display("FAIL nonmem got valid=%0b stall=%0b data=%0h exp 1/0/0", v2, st2, m2); end
        drive(1'b1, SINS, IIADDQ, 64'h0, 64'h0);
        nvec++; if (s2 !== SINS || v2 !== 1'b1) begin nerr++; $display("FAIL sins got stat=%0h valid=%0b exp 4/1", s2, v2); end
        drive(1'b1, SAOK, IRMMOVQ, 64'h50, 64'h9999);
        drive(1'b1, SAOK, IMRMOVQ, 64'h50, 64'h0);
        n = 0;
        while (st2 === 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
        nvec++; if (m2 !== 64'h1234) begin nerr++; $display("FAIL sins_halt got %0h exp 1234", m2); end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; stat = SAOK; icode = INOP; valE = '0; valA = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_upper_bound();
        test_sticky_halt();
        test_reset_mid_read();
        test_lat0();
        test_bubble_other();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
